psum_drain: RTL and testbench
=============================

// Module: psum_drain
// PURPOSE
// - Read side of the channel accumulator. When the input-channel loop ends, it snapshots the
//   LANES x DW partial-sum vector and pulses a clear back to the accumulator.
// - Each lane is post-processed: bias add, optional ReLU, rounded right shift, saturation to OW bits.
// - Lanes are streamed one per beat, lane 0 first, over a valid/ready port to the output feature buffer.
// PARAMETERS
// - LANES  7   number of accumulator lanes (output pixels per row segment)
// - DW     32  accumulator lane width, signed two's complement
// - OW     8   output activation width, signed
// - SHW    5   width of the requant shift amount
// PORTS
// - clk        in   1          clock
// - rst_n      in   1          reset, asynchronous, active-low
// - start      in   1          accumulation finished; capture acc_in (1-cycle pulse)
// - acc_in     in   LANES*DW   accumulator vector; lane i = acc_in[i*DW +: DW]
// - bias       in   DW         signed bias, sampled with start
// - shift      in   SHW        right-shift amount, sampled with start
// - relu_en    in   1          ReLU enable, sampled with start
// - acc_clr    out  1          1-cycle clear pulse to the accumulator
// - busy       out  1          high from capture until final beat accepted
// - out_valid  out  1          output beat valid
// - out_ready  in   1          downstream accepts beat
// - out_data   out  OW         requantized activation, signed
// - out_idx    out  3          lane index of current beat
// - out_last   out  1          current beat is lane LANES-1
// - done       out  1          1-cycle pulse after the last beat is accepted
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0; shadow registers 0. Reset mid-stream aborts with no done.
// - FSM IDLE -> SEND -> IDLE.
// - IDLE: when start=1 at an edge, latch acc_in, bias, shift and relu_en into shadow regs; set busy;
//   load beat for lane 0; go to SEND.
// - Edge after capture: out_valid=1 with lane 0, and acc_clr=1 for exactly that one cycle.
// - SEND: out_data, out_idx and out_last hold stable while out_valid && !out_ready.
// - SEND handshake (valid&ready at an edge), idx<LANES-1: load lane idx+1 in the same edge.
//   Throughput is 1 beat/cycle with ready held high.
// - Handshake with idx==LANES-1: out_valid=0, busy=0, done=1 for one cycle, go to IDLE.
// - start while busy: ignored; shadow regs not disturbed; no second acc_clr.
// - start in the same cycle as the final handshake: ignored (IDLE is entered the next cycle).
// - Requant per lane, signed, no intermediate wrap:
//   - s  = sext(lane) + sext(bias), DW+2 bits
//   - if relu_en && s<0 then s=0
//   - sh = min(shift, DW-1)
//   - r  = (s + (sh>0 ? 1<<(sh-1) : 0)) >>> sh   (arithmetic shift, round half up)
//   - out_data = sat(r) to [-2^(OW-1), 2^(OW-1)-1]; with ReLU the result is in [0, 2^(OW-1)-1]
// - acc_in is not sampled again after capture, so the accumulator may clear or refill while streaming.
// STRUCTURE
// - Shared package: LANES/DW/OW/SHW defaults, state enum {IDLE, SEND}, sat/min helper constants.
// - Sub-module requant_lane: combinational bias + ReLU + round + shift + saturate for one lane.
//   Instantiated once and muxed by the next index; out_data is registered in psum_drain.
// TESTING
// - Basic: lanes = 0..6 x 256, bias=0, shift=8, relu=0, ready=1 ->
//   beats 0,1,...,6 on 7 consecutive cycles; last at idx 6; done 1 cycle later; acc_clr once.
// - Rounding/ReLU: lane0=-384, lane1=384, lane2=383, shift=8.
//   relu=0 -> -1, 2, 1. relu=1 -> 0, 2, 1.
// - Saturation: lane=0x7FFF_FFFF, bias=0x7FFF_FFFF, shift=0 -> 127.
//   lane=0x8000_0000, shift=0, relu=0 -> -128. Also shift=31 clamps without X.
// - Backpressure: ready toggles 1,0,0,1 pseudo-randomly -> data/idx stable while stalled;
//   exactly 7 beats in order; done only after beat 6 is accepted.
// - start while busy (pulse at beat 3) -> ignored, no extra acc_clr, stream unchanged.
//   Also start on the final-handshake cycle -> ignored.
// - rst_n asserted mid-stream at beat 4 -> all outputs 0 immediately.
//   After release, a new start streams cleanly from idx 0.

Source files
------------

// File: rtl/psum_drain_pkg.sv
// -----------------------------------------------------------------------------
// psum_drain_pkg
// Shared definitions for the partial-sum drain block:
//   - default geometry (lanes, accumulator width, output width, shift width)
//   - width of the lane index carried on the output port
//   - FSM state encoding
//   - saturation bound helpers for a signed output of a given width
// -----------------------------------------------------------------------------
package psum_drain_pkg;

    localparam int LANES_DEF = 7;
    localparam int DW_DEF    = 32;
    localparam int OW_DEF    = 8;
    localparam int SHW_DEF   = 5;
    localparam int IDXW      = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Largest value representable by a signed ow-bit number.
    function automatic longint sat_hi(input int ow);
        return (longint'(1) << (ow - 1)) - longint'(1);
    endfunction

    // Smallest value representable by a signed ow-bit number.
    function automatic longint sat_lo(input int ow);
        return -(longint'(1) << (ow - 1));
    endfunction

endpackage

// File: rtl/psum_drain_requant.sv
// -----------------------------------------------------------------------------
// requant_lane
// Combinational requantisation of one accumulator lane:
//   bias add -> optional ReLU -> rounded arithmetic right shift -> saturate.
// The working width is DW+3 so the bias add and the rounding offset can never
// wrap, whatever the operands.
// Ports:
//   i_lane     signed accumulator lane (DW)
//   i_bias     signed bias (DW)
//   i_shift    right-shift amount (SHW), clamped to DW-1
//   i_relu_en  clamp negative sums to zero before shifting
//   o_data     signed saturated result (OW)
// -----------------------------------------------------------------------------
module requant_lane
    import psum_drain_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int OW  = OW_DEF,
    parameter int SHW = SHW_DEF
) (
    input  logic signed [DW-1:0]  i_lane,
    input  logic signed [DW-1:0]  i_bias,
    input  logic        [SHW-1:0] i_shift,
    input  logic                  i_relu_en,
    output logic signed [OW-1:0]  o_data
);

    localparam int SW       = DW + 3;
    localparam int SH_MAX_I = DW - 1;
    localparam logic signed [SW-1:0] SAT_HI = SW'(sat_hi(OW));
    localparam logic signed [SW-1:0] SAT_LO = SW'(sat_lo(OW));

    logic signed [SW-1:0]  w_sum;
    logic signed [SW-1:0]  w_act;
    logic signed [SW-1:0]  w_rnd;
    logic        [SHW-1:0] w_sh;

    function automatic logic signed [SW-1:0] sext(input logic signed [DW-1:0] v);
        return {{(SW-DW){v[DW-1]}}, v};
    endfunction

    // Round half up: add half an LSB of the result, then shift arithmetically.
    function automatic logic signed [SW-1:0] round_shr(input logic signed [SW-1:0] v,
                                                       input logic        [SHW-1:0] sh);
        logic signed [SW-1:0] half;
        half = '0;
        if (sh != '0)
            half = SW'(1) << (sh - SHW'(1));
        return (v + half) >>> sh;
    endfunction

    function automatic logic signed [OW-1:0] sat(input logic signed [SW-1:0] v);
        if (v > SAT_HI)
            return SAT_HI[OW-1:0];
        else if (v < SAT_LO)
            return SAT_LO[OW-1:0];
        return v[OW-1:0];
    endfunction

    always_comb begin
        w_sum = sext(i_lane) + sext(i_bias);
        // ReLU on the sign bit of the full-width sum
        w_act = (i_relu_en && w_sum[SW-1]) ? '0 : w_sum;
        // Compare in int width so the clamp stays meaningful for any SHW/DW mix
        w_sh  = (int'(i_shift) > SH_MAX_I) ? SHW'(SH_MAX_I) : i_shift;
        w_rnd = round_shr(w_act, w_sh);
        o_data = sat(w_rnd);
    end

endmodule

// File: rtl/psum_drain.sv
// -----------------------------------------------------------------------------
// psum_drain
// Read side of the channel accumulator. On start it snapshots the whole
// partial-sum vector plus the requant parameters, pulses acc_clr once, and
// streams one requantised lane per beat (lane 0 first) over valid/ready.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 capture pulse (ignored while busy)
//   acc_in                LANES x DW accumulator vector, lane i at [i*DW +: DW]
//   bias, shift, relu_en  requant parameters, sampled with start
//   acc_clr               one-cycle clear back to the accumulator
//   busy                  capture .. final beat accepted
//   out_valid/out_ready   output handshake
//   out_data              signed OW-bit activation
//   out_idx, out_last     lane index of the beat, high on lane LANES-1
//   done                  one-cycle pulse after the last beat is accepted
// -----------------------------------------------------------------------------
module psum_drain
    import psum_drain_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int DW    = DW_DEF,
    parameter int OW    = OW_DEF,
    parameter int SHW   = SHW_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [LANES*DW-1:0]     acc_in,
    input  logic signed [DW-1:0]    bias,
    input  logic        [SHW-1:0]   shift,
    input  logic                    relu_en,
    output logic                    acc_clr,
    output logic                    busy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OW-1:0]    out_data,
    output logic        [IDXW-1:0]  out_idx,
    output logic                    out_last,
    output logic                    done
);

    // Shadow copy of the capture-time inputs
    logic [LANES*DW-1:0]   r_acc;
    logic signed [DW-1:0]  r_bias;
    logic [SHW-1:0]        r_shift;
    logic                  r_relu;

    // Output beat and control registers
    state_t                r_state;
    state_t                w_state_nxt;
    logic signed [OW-1:0]  r_data;
    logic [IDXW-1:0]       r_idx;
    logic                  r_last;
    logic                  r_valid;
    logic                  r_busy;
    logic                  r_clr;
    logic                  r_done;

    logic                  w_hs;
    logic                  w_capture;
    logic                  w_advance;
    logic                  w_finish;
    logic [IDXW-1:0]       w_nxt_idx;

    // Requant source selection
    logic [IDXW-1:0]       w_sel_idx;
    logic [LANES*DW-1:0]   w_sel_vec;
    logic signed [DW-1:0]  w_sel_lane;
    logic signed [DW-1:0]  w_sel_bias;
    logic [SHW-1:0]        w_sel_shift;
    logic                  w_sel_relu;
    logic signed [OW-1:0]  w_q;

    assign w_hs      = r_valid && out_ready;
    assign w_nxt_idx = r_idx + IDXW'(1);

    // FSM next-state and beat control
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_advance   = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_capture   = 1'b1;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                // start is deliberately not looked at here
                if (w_hs) begin
                    if (r_last) begin
                        w_finish    = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_advance   = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // On capture the shadow regs are not loaded yet, so lane 0 is taken
    // straight from the inputs; afterwards only the shadow copy is used.
    always_comb begin
        w_sel_idx   = w_capture ? '0 : w_nxt_idx;
        w_sel_vec   = w_capture ? acc_in  : r_acc;
        w_sel_bias  = w_capture ? bias    : r_bias;
        w_sel_shift = w_capture ? shift   : r_shift;
        w_sel_relu  = w_capture ? relu_en : r_relu;
        w_sel_lane  = '0;
        for (int i = 0; i < LANES; i++) begin
            if (w_sel_idx == IDXW'(i))
                w_sel_lane = w_sel_vec[i*DW +: DW];
        end
    end

    requant_lane #(
        .DW  (DW),
        .OW  (OW),
        .SHW (SHW)
    ) u_requant (
        .i_lane    (w_sel_lane),
        .i_bias    (w_sel_bias),
        .i_shift   (w_sel_shift),
        .i_relu_en (w_sel_relu),
        .o_data    (w_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Output beat register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_bias  <= '0;
            r_shift <= '0;
            r_relu  <= 1'b0;
            r_data  <= '0;
            r_idx   <= '0;
            r_last  <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_clr   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_clr  <= w_capture;
            r_done <= w_finish;
            if (w_capture) begin
                r_acc   <= acc_in;
                r_bias  <= bias;
                r_shift <= shift;
                r_relu  <= relu_en;
                r_data  <= w_q;
                r_idx   <= '0;
                r_last  <= (LANES == 1);
                r_valid <= 1'b1;
                r_busy  <= 1'b1;
            end else if (w_advance) begin
                r_data  <= w_q;
                r_idx   <= w_nxt_idx;
                r_last  <= (w_nxt_idx == IDXW'(LANES - 1));
            end else if (w_finish) begin
                r_data  <= '0;
                r_idx   <= '0;
                r_last  <= 1'b0;
                r_valid <= 1'b0;
                r_busy  <= 1'b0;
            end
        end
    end

    assign acc_clr   = r_clr;
    assign busy      = r_busy;
    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_idx   = r_idx;
    assign out_last  = r_last;
    assign done      = r_done;

endmodule

// File: tb/tb_psum_drain.sv
// -----------------------------------------------------------------------------
// tb_psum_drain
// Directed-vector bench for psum_drain with hand-computed expected beats.
// -----------------------------------------------------------------------------
module tb_psum_drain;
    import psum_drain_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic [7*32-1:0]     acc_in;
    logic signed [31:0]  bias;
    logic [4:0]          shift;
    logic                relu_en;
    logic                acc_clr;
    logic                busy;
    logic                out_valid;
    logic                out_ready;
    logic signed [7:0]   out_data;
    logic [2:0]          out_idx;
    logic                out_last;
    logic                done;

    int n_vec = 0;
    int n_err = 0;

    logic signed [31:0] L [7];
    int                 E [7];
    logic [15:0]        RDY = 16'b1011_0010_1101_1001;

    psum_drain u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .acc_in    (acc_in),
        .bias      (bias),
        .shift     (shift),
        .relu_en   (relu_en),
        .acc_clr   (acc_clr),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_clr"},   acc_clr,   0);
        chk({tag, "_busy"},  busy,      0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_data"},  out_data,  0);
        chk({tag, "_idx"},   out_idx,   0);
        chk({tag, "_last"},  out_last,  0);
        chk({tag, "_done"},  done,      0);
    endtask

    // Present L[] and parameters with a start pulse, then scramble the inputs
    // so any later resampling would corrupt the stream.
    task automatic capture(input string tag, input logic signed [31:0] b,
                           input logic [4:0] sh, input logic rl);
        for (int i = 0; i < 7; i++) acc_in[i*32 +: 32] = L[i];
        bias    = b;
        shift   = sh;
        relu_en = rl;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        acc_in  = {7{32'h5A5A_A5A5}};
        bias    = 32'sh0012_3456;
        shift   = 5'd3;
        relu_en = ~rl;
        chk({tag, "_cap_clr"},   acc_clr,   1);
        chk({tag, "_cap_busy"},  busy,      1);
        chk({tag, "_cap_valid"}, out_valid, 1);
        chk({tag, "_cap_idx"},   out_idx,   0);
    endtask

    // Drain 7 beats against E[]; optional backpressure, start-while-busy at
    // beat 3, and start on the final-handshake cycle.
    task automatic stream(input string tag, input bit bp, input bit busy_start,
                          input bit last_start);
        int beat = 0;
        int cyc = 0;
        int n_clr = 0;
        int n_early = 0;
        bit stall = 1'b0;
        bit pulsed = 1'b0;
        logic signed [7:0] pd = '0;
        logic [2:0] pi = '0;
        while (beat < 7 && cyc < 200) begin
            if (stall) begin
                chk({tag, "_hold_data"}, out_data, pd);
                chk({tag, "_hold_idx"},  out_idx,  pi);
            end
            if (cyc > 0 && acc_clr) n_clr++;
            if (done) n_early++;
            chk({tag, "_valid"}, out_valid, 1);
            out_ready = bp ? RDY[cyc % 16] : 1'b1;
            start = 1'b0;
            if (busy_start && beat == 3 && !pulsed) begin
                start  = 1'b1;
                pulsed = 1'b1;
                acc_in = {7{32'h0100_0000}};
                bias   = 32'sh4000_0000;
            end
            if (last_start && out_ready && beat == 6) start = 1'b1;
            if (out_ready) begin
                chk({tag, "_idx"},  out_idx,  beat);
                chk({tag, "_data"}, out_data, E[beat]);
                chk({tag, "_last"}, out_last, (beat == 6));
                beat++;
                stall = 1'b0;
            end else begin
                stall = 1'b1;
                pd = out_data;
                pi = out_idx;
            end
            tick();
            cyc++;
            start = 1'b0;
        end
        chk({tag, "_beats"}, beat, 7);
        if (!bp) chk({tag, "_thru"}, cyc, 7);
        chk({tag, "_extra_clr"},  n_clr,   0);
        chk({tag, "_early_done"}, n_early, 0);
        chk({tag, "_done"},     done,      1);
        chk({tag, "_end_valid"}, out_valid, 0);
        chk({tag, "_end_busy"},  busy,      0);
        chk({tag, "_end_clr"},   acc_clr,   0);
        tick();
        chk({tag, "_done_pulse"}, done,      0);
        chk({tag, "_idle_busy"},  busy,      0);
        chk({tag, "_idle_valid"}, out_valid, 0);
        chk({tag, "_idle_clr"},   acc_clr,   0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        acc_in    = '0;
        bias      = '0;
        shift     = '0;
        relu_en   = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        chk_idle("reset");
        rst_n = 1'b1;
        tick();

        // Basic: lane i = i*256, shift 8 -> i
        for (int i = 0; i < 7; i++) begin
            L[i] = 32'(i * 256);
            E[i] = i;
        end
        capture("basic", 32'sd0, 5'd8, 1'b0);
        stream("basic", 1'b0, 1'b0, 1'b0);

        // Rounding, without and with ReLU
        L = '{-32'sd384, 32'sd384, 32'sd383, -32'sd128, 32'sd127, 32'sd128, -32'sd129};
        E = '{-1, 2, 1, 0, 0, 1, -1};
        capture("rnd", 32'sd0, 5'd8, 1'b0);
        stream("rnd", 1'b0, 1'b0, 1'b0);
        E = '{0, 2, 1, 0, 0, 1, 0};
        capture("rnd_relu", 32'sd0, 5'd8, 1'b1);
        stream("rnd_relu", 1'b0, 1'b0, 1'b0);

        // Saturation with maximal bias
        L = '{32'h7FFF_FFFF, 32'h8000_0000, 32'sd0, 32'sd1, -32'sd1, 32'sd100, -32'sd200};
        E = '{127, -1, 127, 127, 127, 127, 127};
        capture("sat_bias", 32'sh7FFF_FFFF, 5'd0, 1'b0);
        stream("sat_bias", 1'b0, 1'b0, 1'b0);

        // Saturation around the output range, shift 0
        L = '{32'h8000_0000, 32'sd100, -32'sd100, 32'sd127, -32'sd129, 32'sd128, 32'sd0};
        E = '{-128, 100, -100, 127, -128, 127, 0};
        capture("sat", 32'sd0, 5'd0, 1'b0);
        stream("sat", 1'b0, 1'b0, 1'b0);
        E = '{0, 100, 0, 127, 0, 127, 0};
        capture("sat_relu", 32'sd0, 5'd0, 1'b1);
        stream("sat_relu", 1'b0, 1'b0, 1'b0);

        // Maximum shift
        L = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h4000_0000, 32'h3FFF_FFFF,
              32'hC000_0000, 32'hBFFF_FFFF, 32'h0};
        E = '{1, -1, 1, 0, 0, -1, 0};
        capture("sh31", 32'sd0, 5'd31, 1'b0);
        stream("sh31", 1'b0, 1'b0, 1'b0);

        // Backpressure, bias 256 -> i+1
        for (int i = 0; i < 7; i++) begin
            L[i] = 32'(i * 256);
            E[i] = i + 1;
        end
        capture("bp", 32'sd256, 5'd8, 1'b0);
        stream("bp", 1'b1, 1'b0, 1'b0);

        // start while busy and on the final handshake
        for (int i = 0; i < 7; i++) E[i] = i;
        capture("busy_start", 32'sd0, 5'd8, 1'b0);
        stream("busy_start", 1'b0, 1'b1, 1'b1);

        // Reset mid-stream at beat 4
        capture("abort", 32'sd0, 5'd8, 1'b0);
        out_ready = 1'b1;
        for (int k = 0; k < 10 && out_idx != 3'd4; k++) tick();
        chk("abort_at4", out_idx, 4);
        rst_n = 1'b0;
        #1;
        chk_idle("abort");
        tick();
        tick();
        chk("abort_no_done", done, 0);
        chk("abort_no_busy", busy, 0);
        rst_n = 1'b1;
        tick();
        capture("post", 32'sd0, 5'd8, 1'b0);
        stream("post", 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
